// File: rtl/sys_mem_stream_wr_agent.sv
// Stream-to-memory write agent: buffers a valid/ready stream in a FIFO and writes it
// word by word into a circular memory partition through the arbiter wait handshake.
module sys_mem_stream_wr_agent #(
    parameter int MEM_DATA_W = 32,
    parameter int MEM_ADDR_W = 27,
    parameter int LB_DATA_W  = 32,
    parameter int LB_ADDR_W  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lb_wr_en,
    input  logic                  lb_rd_en,
    input  logic [LB_ADDR_W-1:0]  lb_addr,
    input  logic [LB_DATA_W-1:0]  lb_wr_data,
    output logic                  lb_wr_valid,
    output logic                  lb_rd_valid,
    output logic [LB_DATA_W-1:0]  lb_rd_data,
    input  logic                  in_valid,
    input  logic [MEM_DATA_W-1:0] in_data,
    output logic                  in_ready,
    input  logic                  mem_wait,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, next_state;
    logic                   en;
    logic [LB_DATA_W-1:0]   start_reg, end_reg;
    logic [MEM_ADDR_W-1:0]  cur_end;
    logic [MEM_ADDR_W-1:0]  wptr;
    logic [LB_DATA_W-1:0]   wrap_cnt;
    logic [MEM_DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count;
    logic                   full, empty, push, pop, load_run, flush;
    logic [LB_DATA_W-1:0]   rd_word;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = in_valid & in_ready;
    assign pop      = mem_wren & ~mem_wait;
    assign load_run = (state == IDLE) && en;
    assign flush    = lb_wr_en && (lb_addr == LB_ADDR_W'(0)) && lb_wr_data[1] && (state == IDLE);

    assign mem_rden  = 1'b0;
    assign mem_addr  = wptr;
    assign mem_wdata = mem_wren ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_wren   = 1'b0;
        case (state)
            IDLE: begin
                if (en) next_state = RUN;
            end
            RUN: begin
                in_ready = en && !full;
                mem_wren = !empty;
                if (!en) next_state = DRAIN;
            end
            DRAIN: begin
                mem_wren = !empty;
                if (en)         next_state = RUN;
                else if (empty) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Storage carries no reset; mem_wdata is gated by mem_wren so stale words never show.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // cur_end latches END only at run start or wrap, so reprogramming mid-run waits for a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            cur_end  <= '0;
            wrap_cnt <= '0;
        end else if (load_run) begin
            wptr     <= start_reg[MEM_ADDR_W-1:0];
            cur_end  <= end_reg[MEM_ADDR_W-1:0];
            wrap_cnt <= '0;
        end else if (pop) begin
            if (wptr >= cur_end) begin
                wptr     <= start_reg[MEM_ADDR_W-1:0];
                cur_end  <= end_reg[MEM_ADDR_W-1:0];
                wrap_cnt <= wrap_cnt + LB_DATA_W'(1);
            end else begin
                wptr <= wptr + MEM_ADDR_W'(1);
            end
        end
    end

    always_comb begin
        rd_word = DEFAULT_DATA_VAL;
        case (lb_addr)
            LB_ADDR_W'(0): begin
                rd_word    = '0;
                rd_word[0] = en;
            end
            LB_ADDR_W'(1): rd_word = start_reg;
            LB_ADDR_W'(2): rd_word = end_reg;
            LB_ADDR_W'(3): begin
                rd_word                 = '0;
                rd_word[MEM_ADDR_W-1:0] = wptr;
            end
            LB_ADDR_W'(4): begin
                rd_word         = '0;
                rd_word[CW-1:0] = count;
                rd_word[16]     = (state != IDLE);
            end
            LB_ADDR_W'(5): rd_word = wrap_cnt;
            default:       rd_word = DEFAULT_DATA_VAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            lb_rd_data  <= '0;
            en          <= 1'b0;
            start_reg   <= '0;
            end_reg     <= '0;
        end else begin
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            if (lb_rd_en) lb_rd_data <= rd_word;
            if (lb_wr_en) begin
                case (lb_addr)
                    LB_ADDR_W'(0): en        <= lb_wr_data[0];
                    LB_ADDR_W'(1): start_reg <= lb_wr_data;
                    LB_ADDR_W'(2): end_reg   <= lb_wr_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/sys_mem_stream_wr_agent.md
Name: sys_mem_stream_wr_agent

Overview:
- Upstream agent for the system-memory arbiter's agent ports.
- Accepts a valid/ready sample stream and buffers it in a small FIFO.
- Issues sequential single-word writes into a memory partition [START_ADDR, END_ADDR], wrapping circularly, honouring the arbiter's wait handshake.
- Local-bus registers: configuration plus status (write pointer, wrap count, occupancy).

Parameters:
- MEM_DATA_W, 32, memory and stream data width.
- MEM_ADDR_W, 27, memory word address width.
- LB_DATA_W, 32, local bus data width.
- LB_ADDR_W, 8, local bus address width.
- FIFO_DEPTH, 8, buffer depth in words; power of 2, ≥2.
- DEFAULT_DATA_VAL, 'hdeadbabe, read data returned for unmapped local bus addresses.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- lb_wr_en  in  1  local bus write strobe.
- lb_rd_en  in  1  local bus read strobe.
- lb_addr  in  LB_ADDR_W  register address.
- lb_wr_data  in  LB_DATA_W  write data.
- lb_wr_valid  out  1  write acknowledge.
- lb_rd_valid  out  1  read data valid.
- lb_rd_data  out  LB_DATA_W  read data.
- in_valid  in  1  stream beat valid.
- in_data  in  MEM_DATA_W  stream beat.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- mem_wait  in  1  arbiter stall; connects to agent_wait.
- mem_wren  out  1  write request; connects to agent_wren.
- mem_rden  out  1  tied 0.
- mem_addr  out  MEM_ADDR_W  write address.
- mem_wdata  out  MEM_DATA_W  write data.

Behaviour:
- Clock/reset: single clock clk; rst_n is asynchronous, active-low.
- Reset: all outputs 0; lb_rd_data 0; FIFO empty; state IDLE; all registers 0.
- Registers, all accesses acknowledged:
  - lb_wr_valid / lb_rd_valid pulse 1 cycle after the strobe.
  - lb_rd_data is valid in the same cycle as lb_rd_valid.
  - Unmapped reads return DEFAULT_DATA_VAL; unmapped writes are ignored but acknowledged.
- Register map:
  - 0x00 CTRL: bit0 EN (RW); bit1 FLUSH (write-1, self-clearing, honoured only in IDLE).
  - 0x01 START_ADDR (RW).
  - 0x02 END_ADDR (RW).
  - 0x03 WPTR (RO).
  - 0x04 STATUS (RO): [15:0] FIFO occupancy; bit16 busy (state≠IDLE).
  - 0x05 WRAP_CNT (RO; cleared on EN 0→1; wraps at 2^LB_DATA_W).
- FSM: IDLE → RUN → DRAIN.
  - IDLE: in_ready=0, mem_wren=0. On EN=1: WPTR←START_ADDR, WRAP_CNT←0, go RUN.
  - RUN: in_ready = !fifo_full. On EN=0: go DRAIN.
  - DRAIN: in_ready=0; keep writing until the FIFO is empty and no request is pending, then go IDLE. EN=1 during DRAIN: return to RUN without reloading WPTR.
- Memory handshake:
  - mem_wren=1 whenever state≠IDLE and FIFO non-empty.
  - mem_addr=WPTR; mem_wdata=FIFO head (show-ahead).
  - Transfer completes on a cycle with mem_wren&!mem_wait. Then: FIFO pops; WPTR advances.
  - While mem_wait=1, mem_wren/addr/wdata hold stable.
- Address rule:
  - After a completed transfer, if WPTR ≥ END_ADDR then WPTR←START_ADDR and WRAP_CNT+1; else WPTR+1.
  - START_ADDR=END_ADDR: every write goes to START_ADDR; wrap counted each write.
  - START/END writes while busy take effect only at the next wrap or EN rise.
- Latency and FIFO:
  - A beat accepted in cycle N is eligible on mem_wren at N+1 at the earliest.
  - Sustained throughput: 1 write/cycle with mem_wait=0.
  - Simultaneous push and pop: occupancy unchanged; permitted when full.
  - in_ready deasserts at occupancy FIFO_DEPTH; no data is ever dropped.
- FLUSH in IDLE empties the FIFO next cycle.
- Reset mid-operation: immediate abort; outstanding FIFO data discarded; no further writes.

Test Plan:
- START=0x100, END=0x103, EN=1, 4 beats 0xA0..0xA3, mem_wait=0 -> writes to 0x100..0x103 on consecutive cycles; WPTR=0x100; WRAP_CNT=1.
- mem_wait=1 for 5 cycles during the 2nd write -> mem_addr=0x101, wdata=0xA1 held stable all 5 cycles; no skipped or duplicated address.
- FIFO_DEPTH=8, mem_wait stuck 1, 10 beats offered -> in_ready falls after the 8th; on release, all 10 written in order.
- 6 beats queued, EN cleared -> in_ready=0 immediately; all 6 written; busy=0 after the last write; STATUS occupancy=0.
- START=END=0x20, 3 beats -> all three writes at 0x20; WRAP_CNT=3.
- Read lb_addr 0x7F -> lb_rd_valid one cycle later with 0xdeadbabe; write to 0x7F -> lb_wr_valid pulse, no register changes.
